// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived sync positions and
// small helpers, so the raster timer and downstream pattern generators agree.
package vga_timing_pkg;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FCNT_W = 8;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Inclusive sync pulse bounds: 656..751 and 490..491 for the defaults.
  localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] pos_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } vid_ctl_t;

  function automatic logic in_span(input pos_t pos, input int unsigned first,
                                   input int unsigned len);
    return (32'(pos) >= first) && (32'(pos) < first + len);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  function automatic logic fits_cnt(input int unsigned total);
    return (total >= 1) && (total <= (1 << CNT_W));
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-N counter with enable; exposes the next-state value so callers can
// register values derived from it in the same edge as the count itself.
module vga_mod_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(N - 1));
  assign o_wrap   = i_en & w_at_max;
  assign o_count  = r_count;

  always_comb begin
    o_next = r_count;
    if (rst) begin
      o_next = '0;
    end else if (i_en) begin
      o_next = w_at_max ? '0 : r_count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timer: horizontal/vertical position counters, registered sync and
// display-enable outputs, line/frame strobes and a free-running frame counter.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [CNT_W-1:0]  hpos,
  output logic [CNT_W-1:0]  vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;

  if (!fits_cnt(H_TOTAL) || !fits_cnt(V_TOTAL)) begin : g_bad_total
    $error("vga_timing: line or frame total does not fit the position counters");
  end

  pos_t w_hpos;
  pos_t w_vpos;
  pos_t w_hnext;
  pos_t w_vnext;
  logic w_hwrap;
  logic w_vwrap;

  vga_mod_counter #(
    .N (H_TOTAL),
    .W (CNT_W)
  ) u_hcnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (pix_en),
    .o_count (w_hpos),
    .o_next  (w_hnext),
    .o_wrap  (w_hwrap)
  );

  vga_mod_counter #(
    .N (V_TOTAL),
    .W (CNT_W)
  ) u_vcnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_hwrap),
    .o_count (w_vpos),
    .o_next  (w_vnext),
    .o_wrap  (w_vwrap)
  );

  vid_ctl_t           r_ctl;
  logic [FCNT_W-1:0]  r_frame_cnt;

  // Controls are derived from next-state positions so they line up with hpos/vpos
  // on the same edge; holding pix_en low leaves next == current, so they hold too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl.hsync   <= ~SYNC_POL;
      r_ctl.vsync   <= ~SYNC_POL;
      r_ctl.visible <= 1'b1;
      r_frame_cnt   <= '0;
    end else begin
      r_ctl.hsync   <= sync_level(in_span(w_hnext, H_SYNC_START, H_SYNC), SYNC_POL);
      r_ctl.vsync   <= sync_level(in_span(w_vnext, V_SYNC_START, V_SYNC), SYNC_POL);
      r_ctl.visible <= in_span(w_hnext, 0, H_ACTIVE) & in_span(w_vnext, 0, V_ACTIVE);
      if (w_vwrap) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  assign hpos      = w_hpos;
  assign vpos      = w_vpos;
  assign hsync     = r_ctl.hsync;
  assign vsync     = r_ctl.vsync;
  assign frame_cnt = r_frame_cnt;

  // visible already describes (0,0) through reset; rst only blanks the pin, so the
  // first cycle after release reports the origin as displayed.
  assign display_on  = r_ctl.visible & ~rst;
  assign line_start  = (w_hpos == '0) & pix_en & ~rst;
  assign frame_start = line_start & (w_vpos == '0);

endmodule
